// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a small output FIFO.
// Each accepted instruction is decoded in the same cycle. The immediate, the
// format code and the illegal flag are written into a DEPTH-entry FIFO, so
// decode can keep running while the execute stage stalls.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  input  logic            lt_flag,
  output logic            imm_valid,
  input  logic            imm_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_t;

  logic [63:0]     dec_wide;
  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            dec_ill;

  logic [XLEN-1:0] imm_mem [DEPTH];
  fmt_t            fmt_mem [DEPTH];
  logic            ill_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic push;
  logic pop;
  logic s;

  assign s = inst[31];

  // Ready and valid come only from the registered count. A pop therefore
  // never opens the input in the same cycle that it frees a slot.
  assign inst_ready = (count != FULL_COUNT);
  assign imm_valid  = (count != '0);
  assign push       = inst_valid && inst_ready;
  assign pop        = imm_valid && imm_ready;

  // The head entry is always shown. When the FIFO is empty it is stale.
  assign imm     = imm_mem[rd_ptr];
  assign fmt     = fmt_mem[rd_ptr];
  assign illegal = ill_mem[rd_ptr];

  // Decode the opcode into a 64-bit sign-extended immediate, then trim it to
  // XLEN. This handles XLEN=32 without a zero-width replication.
  always_comb begin
    dec_wide = '0;
    dec_fmt  = FMT_ILL;
    dec_ill  = 1'b1;
    case (inst[6:0])
      7'b0110011: begin
        dec_wide = {63'b0, lt_flag};
        dec_fmt  = FMT_R;
        dec_ill  = 1'b0;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_wide = {{52{s}}, inst[31:20]};
        dec_fmt  = FMT_I;
        dec_ill  = 1'b0;
      end
      7'b0100011: begin
        dec_wide = {{52{s}}, inst[31:25], inst[11:7]};
        dec_fmt  = FMT_S;
        dec_ill  = 1'b0;
      end
      7'b1100011: begin
        dec_wide = {{51{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        dec_fmt  = FMT_B;
        dec_ill  = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        dec_wide = {{32{s}}, inst[31:12], 12'b0};
        dec_fmt  = FMT_U;
        dec_ill  = 1'b0;
      end
      7'b1101111: begin
        dec_wide = {{43{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        dec_fmt  = FMT_J;
        dec_ill  = 1'b0;
      end
      default: begin
        dec_wide = '0;
        dec_fmt  = FMT_ILL;
        dec_ill  = 1'b1;
      end
    endcase
  end

  assign dec_imm = dec_wide[XLEN-1:0];

  // Storage is cleared on reset so the stale head after reset reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem[i] <= '0;
        fmt_mem[i] <= FMT_R;
        ill_mem[i] <= 1'b0;
      end
    end else if (push) begin
      imm_mem[wr_ptr] <= dec_imm;
      fmt_mem[wr_ptr] <= dec_fmt;
      ill_mem[wr_ptr] <= dec_ill;
    end
  end

  // The pointers wrap naturally because DEPTH is a power of two. The count
  // tracks occupancy so that full and empty can be told apart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed test of imm_gen_pipe at XLEN=64. A second XLEN=32
// copy shares the same stimulus so the U-type truncation can be observed.
module tb_imm_gen_pipe;

  logic        clk;
  logic        reset;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        lt_flag;
  logic        imm_valid;
  logic        imm_ready;
  logic [63:0] imm;
  logic [2:0]  fmt;
  logic        illegal;

  logic        inst_ready32;
  logic        imm_valid32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        illegal32;

  int passCount  = 0;
  int checkCount = 0;

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .lt_flag(lt_flag), .imm_valid(imm_valid), .imm_ready(imm_ready),
    .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready32),
    .inst(inst), .lt_flag(lt_flag), .imm_valid(imm_valid32), .imm_ready(imm_ready),
    .imm(imm32), .fmt(fmt32), .illegal(illegal32)
  );

  // 10 ns clock, with rising edges at 5, 15, 25 ns and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  // Present one set of inputs, then advance past the next rising edge so that
  // the outputs are sampled 1 ns after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] word, input logic lt, input logic rdy);
    inst_valid = v;
    inst       = word;
    lt_flag    = lt;
    imm_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    inst_valid = 1'b0;
    inst       = 32'h0;
    lt_flag    = 1'b0;
    imm_ready  = 1'b0;
    #12;
    reset = 1'b0;
    #1;

    // Reset state.
    checkOutput("rst_valid",   {63'b0, imm_valid},  64'd0);
    checkOutput("rst_ready",   {63'b0, inst_ready}, 64'd1);
    checkOutput("rst_imm",     imm,                 64'd0);
    checkOutput("rst_fmt",     {61'b0, fmt},        64'd0);
    checkOutput("rst_illegal", {63'b0, illegal},    64'd0);

    // addi x1,x0,-1, followed by one idle cycle.
    applyStimulus(1'b1, 32'hFFF00093, 1'b0, 1'b1);
    checkOutput("addi_valid",   {63'b0, imm_valid}, 64'd1);
    checkOutput("addi_imm",     imm,                64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_fmt",     {61'b0, fmt},       64'd1);
    checkOutput("addi_illegal", {63'b0, illegal},   64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("addi_drained", {63'b0, imm_valid}, 64'd0);

    // A back-to-back stream with the consumer always ready.
    applyStimulus(1'b1, 32'hFE000EE3, 1'b0, 1'b1);
    checkOutput("beq_imm", imm,          64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("beq_fmt", {61'b0, fmt}, 64'd3);
    applyStimulus(1'b1, 32'h0080006F, 1'b0, 1'b1);
    checkOutput("jal_valid", {63'b0, imm_valid}, 64'd1);
    checkOutput("jal_imm",   imm,                64'h8);
    checkOutput("jal_fmt",   {61'b0, fmt},       64'd5);
    applyStimulus(1'b1, 32'h00113823, 1'b0, 1'b1);
    checkOutput("sd_imm", imm,          64'h10);
    checkOutput("sd_fmt", {61'b0, fmt}, 64'd2);
    applyStimulus(1'b1, 32'h800000B7, 1'b0, 1'b1);
    checkOutput("lui_imm64",  imm,           64'hFFFF_FFFF_8000_0000);
    checkOutput("lui_imm32",  {32'b0, imm32}, 64'h0000_0000_8000_0000);
    checkOutput("lui_fmt",    {61'b0, fmt},   64'd4);
    applyStimulus(1'b1, 32'h0020A033, 1'b1, 1'b1);
    checkOutput("slt1_imm", imm,          64'd1);
    checkOutput("slt1_fmt", {61'b0, fmt}, 64'd0);
    applyStimulus(1'b1, 32'h0020A033, 1'b0, 1'b1);
    checkOutput("slt0_imm", imm, 64'd0);
    applyStimulus(1'b1, 32'h0000007F, 1'b0, 1'b1);
    checkOutput("ill_imm",     imm,              64'd0);
    checkOutput("ill_fmt",     {61'b0, fmt},     64'd7);
    checkOutput("ill_illegal", {63'b0, illegal}, 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stream_drained", {63'b0, imm_valid}, 64'd0);

    // Back-pressure: the consumer stalls, and three pushes are attempted.
    applyStimulus(1'b1, 32'h00100093, 1'b0, 1'b0);
    checkOutput("bp1_ready", {63'b0, inst_ready}, 64'd1);
    checkOutput("bp1_imm",   imm,                 64'd1);
    applyStimulus(1'b1, 32'h00200093, 1'b0, 1'b0);
    checkOutput("bp2_ready", {63'b0, inst_ready}, 64'd0);
    checkOutput("bp2_hold",  imm,                 64'd1);
    applyStimulus(1'b1, 32'h00300093, 1'b0, 1'b0);
    checkOutput("bp3_ready", {63'b0, inst_ready}, 64'd0);
    checkOutput("bp3_valid", {63'b0, imm_valid},  64'd1);
    checkOutput("bp3_hold",  imm,                 64'd1);
    // Release the consumer. The first pop frees a slot but blocks the push.
    applyStimulus(1'b1, 32'h00300093, 1'b0, 1'b1);
    checkOutput("drain1_imm",   imm,                 64'd2);
    checkOutput("drain1_ready", {63'b0, inst_ready}, 64'd1);
    // Push and pop happen together at count=1, and the head becomes the new word.
    applyStimulus(1'b1, 32'h00300093, 1'b0, 1'b1);
    checkOutput("pushpop_valid", {63'b0, imm_valid}, 64'd1);
    checkOutput("pushpop_imm",   imm,                64'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("drain3_valid", {63'b0, imm_valid}, 64'd0);

    // Fill the FIFO with two entries, then reset asynchronously between edges.
    applyStimulus(1'b1, 32'h00500093, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00600093, 1'b0, 1'b0);
    checkOutput("pre_rst_ready", {63'b0, inst_ready}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", {63'b0, imm_valid},  64'd0);
    checkOutput("async_rst_ready", {63'b0, inst_ready}, 64'd1);
    checkOutput("async_rst_imm",   imm,                 64'd0);
    // A push attempted while reset is held must leave no entry behind.
    applyStimulus(1'b1, 32'h00700093, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("rst_push_ignored", {63'b0, imm_valid}, 64'd0);
    applyStimulus(1'b1, 32'h0080006F, 1'b0, 1'b0);
    checkOutput("post_rst_valid", {63'b0, imm_valid}, 64'd1);
    checkOutput("post_rst_imm",   imm,                64'h8);
    checkOutput("post_rst_fmt",   {61'b0, fmt},       64'd5);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the RISC-V datapath. It accepts 32-bit instruction words over a valid/ready handshake and decodes the immediate for every base format (R-flag, I, S, B, U, J) at width XLEN. Results are buffered in a DEPTH-entry FIFO so decode can run ahead of a stalled execute stage. It sits between the instruction register and the ALU-B / branch-target muxes and replaces the combinational sign extender with a pipelined, back-pressured stage.

## Interface
- XLEN, 64, result width; legal values 32 and 64.
- DEPTH, 2, output FIFO entries; power of two, at least 2.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_valid  in  1  inst/lt_flag valid this cycle.
- inst_ready  out  1  block can accept; equals (count != DEPTH).
- inst  in  32  instruction word.
- lt_flag  in  1  ALU less-than result for the slt family.
- imm_valid  out  1  FIFO head valid; equals (count != 0).
- imm_ready  in  1  consumer takes the head this cycle.
- imm  out  XLEN  decoded immediate at the FIFO head.
- fmt  out  3  format at the head: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- illegal  out  1  head opcode is not in the decode list below.

## Operation
- Push occurs when inst_valid && inst_ready. Pop occurs when imm_valid && imm_ready.
- Decode is a pure function of inst[6:0] (and lt_flag); sign bit s = inst[31]; every result is sign-extended to XLEN unless stated otherwise.
  - 0110011 R: imm = zero-extended lt_flag (1 or 0); fmt 0.
  - 0010011, 0000011, 1100111 I: imm = sext(inst[31:20]); fmt 1.
  - 0100011 S: imm = sext({inst[31:25], inst[11:7]}); fmt 2.
  - 1100011 B: imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13 bits; fmt 3.
  - 0110111, 0010111 U: imm = sext({inst[31:12], 12'b0}); at XLEN=32 there is no extension; fmt 4.
  - 1101111 J: imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21 bits; fmt 5.
  - Any other opcode: imm = 0, fmt 7, illegal = 1. The entry is still pushed and popped normally.
- Every output bit is driven in every decode case; the decoder contains no latches and no partial assignments.
- FIFO storage: write pointer and read pointer of log2(DEPTH) bits each, both wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - Push only: count+1.
  - Pop only: count-1.
  - Both: count unchanged; both pointers advance.
- When full, inst_ready is 0 even if a pop happens in the same cycle; there is no combinational ready path from imm_ready to inst_ready.
- When empty, imm, fmt and illegal show the entry at the read pointer, which is stale. Consumers must qualify these outputs with imm_valid.

## Timing
- Reset (asynchronous, takes effect immediately): count=0, both pointers=0, imm_valid=0, inst_ready=1, imm=0, fmt=0, illegal=0. Storage entries are cleared to 0.
- Reset asserted mid-operation discards all buffered entries. A push or pop in the reset cycle has no effect.
- Latency: an instruction pushed at edge N is visible on imm/imm_valid after edge N, i.e. one cycle later. There is no bypass when the FIFO is empty.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- A consumer that holds imm_ready=1 sees back-to-back entries with no bubble.
- imm, fmt and illegal are held stable while imm_valid=1 and imm_ready=0.
- inst_ready and imm_valid are registered-state functions of count only.

## Test plan
- XLEN=64, single push of addi 0xFFF00093 with imm_ready=1 -> next cycle imm_valid=1, imm=0xFFFF_FFFF_FFFF_FFFF, fmt=1; the cycle after, imm_valid=0.
- beq 0xFE000EE3 -> imm=0xFFFF_FFFF_FFFF_FFFC, fmt=3. jal 0x0080006F -> imm=0x8, fmt=5. sd 0x00113823 -> imm=0x10, fmt=2.
- lui 0x800000B7 -> at XLEN=64 imm=0xFFFF_FFFF_8000_0000; at XLEN=32 imm=0x8000_0000. R-type 0x0020A033 with lt_flag=1 -> imm=1; with lt_flag=0 -> imm=0.
- DEPTH=2, imm_ready=0, three consecutive pushes -> inst_ready drops after the second push and the third word stalls. Then raise imm_ready -> entries drain in order, and inst_ready returns to 1 one cycle after the first pop.
- Opcode 0x0000007F -> illegal=1, fmt=7, imm=0. Simultaneous push and pop at count=1 -> count stays 1 and the output changes to the new entry.
- With 2 entries buffered, assert reset asynchronously between clock edges -> imm_valid=0 and inst_ready=1 immediately. After release, the first push appears after 1 cycle with the correct value.
